// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, one-cycle flush/redirect,
// stall-cycle counter and stuck-stall watchdog.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            stalled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 6'b000000;
    flush    = 1'b0;
    unique case (state)
      RUN: begin
        if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
        if (flush_req) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        flush    = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    // Hold-free while in reset even if requests are still up.
    if (rst) begin
      stall = 6'b000000;
    end
  end

  assign stalled = |stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_pc <= 32'h0;
    end else if (state == RUN && flush_req) begin
      new_pc <= flush_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stalled) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!stalled) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(STALL_TIMEOUT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_timeout <= 1'b0;
    end else if (stalled && wd_cnt == WD_W'(STALL_TIMEOUT - 1)) begin
      stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl
// (STALL_TIMEOUT=8, CNT_W=4).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles;
  logic        stall_timeout;

  int n_vec;
  int n_bad;

  pipe_ctrl #(
    .STALL_TIMEOUT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_if(stallreq_if),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .flush_req(flush_req),
    .flush_pc(flush_pc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_cycles(stall_cycles),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(4'b0000);
    flush_req = 1'b0;
    flush_pc  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           req      fr    fpc           stall  fl  pc           cnt
    tbl[0]  = '{4'b0011, 1'b0, 32'h0,       6'h07, 0, 32'h0,       4'd0};
    tbl[1]  = '{4'b0111, 1'b0, 32'h0,       6'h0F, 0, 32'h0,       4'd1};
    tbl[2]  = '{4'b1111, 1'b0, 32'h0,       6'h1F, 0, 32'h0,       4'd2};
    tbl[3]  = '{4'b0000, 1'b0, 32'h0,       6'h00, 0, 32'h0,       4'd3};
    tbl[4]  = '{4'b0000, 1'b0, 32'h0,       6'h00, 0, 32'h0,       4'd3};
    tbl[5]  = '{4'b0100, 1'b1, 32'h180,     6'h0F, 0, 32'h0,       4'd3};
    tbl[6]  = '{4'b0000, 1'b0, 32'h0,       6'h00, 1, 32'h180,     4'd4};
    tbl[7]  = '{4'b0000, 1'b0, 32'h0,       6'h00, 0, 32'h0,       4'd4};
    tbl[8]  = '{4'b1000, 1'b1, 32'h200,     6'h1F, 0, 32'h0,       4'd4};
    tbl[9]  = '{4'b1000, 1'b1, 32'h300,     6'h00, 1, 32'h200,     4'd5};
    tbl[10] = '{4'b1000, 1'b1, 32'h400,     6'h1F, 0, 32'h0,       4'd5};
    tbl[11] = '{4'b0000, 1'b0, 32'h0,       6'h00, 1, 32'h400,     4'd6};
    tbl[12] = '{4'b0001, 1'b0, 32'h0,       6'h03, 0, 32'h0,       4'd6};
    tbl[13] = '{4'b0000, 1'b0, 32'h0,       6'h00, 0, 32'h0,       4'd7};
    tbl[14] = '{4'b0010, 1'b0, 32'h0,       6'h07, 0, 32'h0,       4'd7};
    tbl[15] = '{4'b1000, 1'b0, 32'h0,       6'h1F, 0, 32'h0,       4'd8};
    tbl[16] = '{4'b0100, 1'b0, 32'h0,       6'h0F, 0, 32'h0,       4'd9};
    tbl[17] = '{4'b0000, 1'b0, 32'h0,       6'h00, 0, 32'h0,       4'd10};

    rst = 1'b1;
    set_req(4'b0000);
    flush_req = 1'b0;
    flush_pc  = 32'h0;
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_cnt", 32'(stall_cycles), 32'h0);
    chk("rst_to", 32'(stall_timeout), 32'h0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      set_req(tbl[i].req);
      flush_req = tbl[i].fr;
      flush_pc  = tbl[i].fpc;
      #3;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      if (tbl[i].e_flush) begin
        chk($sformatf("v%0d_newpc", i), new_pc, tbl[i].e_pc);
      end
      chk($sformatf("v%0d_cnt", i), 32'(stall_cycles), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_to", i), 32'(stall_timeout), 32'h0);
      next_cyc();
    end

    // Async reset landing in a FLUSH cycle with mem still requesting
    set_req(4'b1000);
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0abc;
    next_cyc();
    chk("pre_rst_flush", 32'(flush), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_flush", 32'(flush), 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_cnt", 32'(stall_cycles), 32'h0);
    chk("midrst_newpc", new_pc, 32'h0);
    do_reset();
    #3;
    chk("postrst_flush", 32'(flush), 32'h0);
    next_cyc();

    // Watchdog: 7 stalled, 1 idle, 8 stalled
    do_reset();
    set_req(4'b0010);
    repeat (7) next_cyc();
    chk("wd_burst1", 32'(stall_timeout), 32'h0);
    set_req(4'b0000);
    next_cyc();
    set_req(4'b0010);
    repeat (7) next_cyc();
    chk("wd_burst2_7", 32'(stall_timeout), 32'h0);
    next_cyc();
    chk("wd_burst2_8", 32'(stall_timeout), 32'h1);
    chk("wd_cnt15", 32'(stall_cycles), 32'hF);
    set_req(4'b0000);
    repeat (3) next_cyc();
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // Counter wrap: 17 stalled edges on a 4-bit counter
    do_reset();
    set_req(4'b0001);
    repeat (17) next_cyc();
    set_req(4'b0000);
    #2;
    chk("wrap_cnt", 32'(stall_cycles), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
